// File: rtl/cubehash_pkg.sv
// Shared definitions for the CubeHash round sequencer: FSM state encoding,
// default round parameters and datapath geometry.
package cubehash_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_WAIT_BLK,
    S_ABSORB,
    S_BLKRND,
    S_FINXOR,
    S_FINAL,
    S_DONE
  } seq_state_e;

  localparam int DEF_ROUNDS    = 16;
  localparam int DEF_INIT_MULT = 10;
  localparam int DEF_FIN_MULT  = 10;

  localparam int STATE_WORDS = 32;
  localparam int BLOCK_W     = 256;

endpackage

// File: rtl/cubehash_round_counter.sv
// Loadable round counter; the terminal-count limit is an input so the
// sequencer can pick it per phase.
module cubehash_round_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst_p)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/cubehash_round_sequencer.sv
// Cycle-level scheduler for the iterative CubeHash datapath (one round/clock).
// Optional macro CUBEHASH_PRECOMP_IV_EN: load a precomputed IV and skip INIT.
module cubehash_round_sequencer
  import cubehash_pkg::*;
#(
  parameter int ROUNDS    = DEF_ROUNDS,
  parameter int INIT_MULT = DEF_INIT_MULT,
  parameter int FIN_MULT  = DEF_FIN_MULT,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_p,
  input  logic start,
  input  logic blk_valid,
  input  logic blk_last,
  output logic blk_ready,
  input  logic hash_ack,
  output logic st_ld_init,
  output logic st_xor_msg,
  output logic st_round,
  output logic st_xor_fin,
  output logic busy,
  output logic hash_valid,
  output logic err
);

`ifndef CUBEHASH_PRECOMP_IV_EN
  localparam logic [CNT_W-1:0] INIT_LIM = CNT_W'(INIT_MULT * ROUNDS - 1);
`endif
  localparam logic [CNT_W-1:0] BLK_LIM  = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] FIN_LIM  = CNT_W'(FIN_MULT * ROUNDS - 1);

  seq_state_e       state_q, state_d;
  logic             last_q;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_limit;
  logic [CNT_W-1:0] cnt;

  cubehash_round_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_p (rst_p),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT_BLK && blk_valid) last_q <= blk_last;
    end
  end

  always_comb begin
    state_d    = state_q;
    blk_ready  = 1'b0;
    st_ld_init = 1'b0;
    st_xor_msg = 1'b0;
    st_round   = 1'b0;
    st_xor_fin = 1'b0;
    hash_valid = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_limit  = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        st_ld_init = 1'b1;
        cnt_clr    = 1'b1;
`ifdef CUBEHASH_PRECOMP_IV_EN
        state_d    = S_WAIT_BLK;
`else
        state_d    = S_INIT;
`endif
      end
`ifndef CUBEHASH_PRECOMP_IV_EN
      S_INIT: begin
        st_round  = 1'b1;
        cnt_limit = INIT_LIM;
        if (cnt_tc) begin
          state_d = S_WAIT_BLK;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
`endif
      S_WAIT_BLK: begin
        blk_ready = 1'b1;
        if (blk_valid) state_d = S_ABSORB;
      end
      S_ABSORB: begin
        st_xor_msg = 1'b1;
        cnt_clr    = 1'b1;
        state_d    = S_BLKRND;
      end
      S_BLKRND: begin
        st_round  = 1'b1;
        cnt_limit = BLK_LIM;
        if (cnt_tc) begin
          state_d = last_q ? S_FINXOR : S_WAIT_BLK;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_FINXOR: begin
        st_xor_fin = 1'b1;
        cnt_clr    = 1'b1;
        state_d    = S_FINAL;
      end
      S_FINAL: begin
        st_round  = 1'b1;
        cnt_limit = FIN_LIM;
        if (cnt_tc) begin
          state_d = S_DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        hash_valid = 1'b1;
        // Back-to-back hashes: an ack paired with start goes straight to LOAD.
        if (hash_ack) state_d = start ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err  = start && (busy || (state_q == S_DONE && !hash_ack));

endmodule
